// File: rtl/popcount_frame_acc.sv
// Frame accumulator for 4-bit ones-count words: sums FRAME_LEN words and
// offers the total on a valid/ready port. Optional macro POPACC_RANGE_CHECK_EN.
module popcount_frame_acc #(
    parameter int FRAME_LEN = 16,
    parameter int ACC_W     = 8,
    parameter int WCNT_W    = $clog2(FRAME_LEN) + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        in_count,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_sum,
    output logic [WCNT_W-1:0] out_words,
    output logic              err
);

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_t;

    localparam logic [WCNT_W-1:0] LAST_IDX    = WCNT_W'(FRAME_LEN - 1);
    localparam logic [WCNT_W-1:0] FRAME_WORDS = WCNT_W'(FRAME_LEN);

    state_t             state_reg, state_next;
    logic [ACC_W-1:0]   acc_reg, acc_next;
    logic [WCNT_W-1:0]  wcnt_reg, wcnt_next;
    logic               out_valid_reg, out_valid_next;
    logic [ACC_W-1:0]   out_sum_reg, out_sum_next;
    logic [WCNT_W-1:0]  out_words_reg, out_words_next;

    logic [3:0]         add_val;
    logic [ACC_W-1:0]   acc_sum;
    logic               accept;

    // clear blocks acceptance so a word arriving alongside it is dropped
    assign in_ready = (state_reg == ACCUM) && !clear;
    assign accept   = in_valid && in_ready;

`ifdef POPACC_RANGE_CHECK_EN
    logic err_reg, err_next;

    assign add_val = (in_count > 4'd9) ? 4'd9 : in_count;

    always_comb begin
        err_next = err_reg;
        if (clear) begin
            err_next = 1'b0;
        end else if (accept && (in_count > 4'd9)) begin
            err_next = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_reg <= 1'b0;
        end else begin
            err_reg <= err_next;
        end
    end

    assign err = err_reg;
`else
    assign add_val = in_count;
    assign err     = 1'b0;
`endif

    assign acc_sum = acc_reg + ACC_W'(add_val);

    always_comb begin
        state_next     = state_reg;
        acc_next       = acc_reg;
        wcnt_next      = wcnt_reg;
        out_valid_next = out_valid_reg;
        out_sum_next   = out_sum_reg;
        out_words_next = out_words_reg;

        if (clear) begin
            // abort restarts the frame but leaves the last reported total visible
            state_next     = ACCUM;
            acc_next       = '0;
            wcnt_next      = '0;
            out_valid_next = 1'b0;
        end else begin
            case (state_reg)
                ACCUM: begin
                    if (accept) begin
                        if (wcnt_reg == LAST_IDX) begin
                            out_sum_next   = acc_sum;
                            out_words_next = FRAME_WORDS;
                            out_valid_next = 1'b1;
                            acc_next       = '0;
                            wcnt_next      = '0;
                            state_next     = HOLD;
                        end else begin
                            acc_next  = acc_sum;
                            wcnt_next = wcnt_reg + WCNT_W'(1);
                        end
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        out_valid_next = 1'b0;
                        state_next     = ACCUM;
                    end
                end
                default: begin
                    state_next = ACCUM;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= ACCUM;
            acc_reg       <= '0;
            wcnt_reg      <= '0;
            out_valid_reg <= 1'b0;
            out_sum_reg   <= '0;
            out_words_reg <= '0;
        end else begin
            state_reg     <= state_next;
            acc_reg       <= acc_next;
            wcnt_reg      <= wcnt_next;
            out_valid_reg <= out_valid_next;
            out_sum_reg   <= out_sum_next;
            out_words_reg <= out_words_next;
        end
    end

    assign out_valid = out_valid_reg;
    assign out_sum   = out_sum_reg;
    assign out_words = out_words_reg;

endmodule

// File: tb/tb_popcount_frame_acc.sv
// Scoreboard bench for popcount_frame_acc: directed frames push expected
// totals; a negedge monitor pops and compares on every output handshake.
module tb_popcount_frame_acc;

    localparam int FRAME_LEN = 16;
    localparam int ACC_W     = 8;
    localparam int WCNT_W    = $clog2(FRAME_LEN) + 1;

    logic              clk;
    logic              rst_n;
    logic              clear;
    logic              in_valid;
    logic              in_ready;
    logic [3:0]        in_count;
    logic              out_valid;
    logic              out_ready;
    logic [ACC_W-1:0]  out_sum;
    logic [WCNT_W-1:0] out_words;
    logic              err;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int sum;
        int words;
    } exp_t;

    exp_t sb[$];

    popcount_frame_acc #(
        .FRAME_LEN(FRAME_LEN),
        .ACC_W    (ACC_W)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (clear),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_count (in_count),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_sum  (out_sum),
        .out_words(out_words),
        .err      (err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d t=%0t", nm, act, exp, $time);
        end else begin
            $display("ok   %s value=%0d t=%0t", nm, act, $time);
        end
    endtask

    task automatic push_exp(input int s, input int w);
        exp_t e;
        e.sum   = s;
        e.words = w;
        sb.push_back(e);
    endtask

    // monitor: one comparison pair per output handshake
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready && !clear) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_frame out_sum=%0d expected=none t=%0t", out_sum, $time);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("frame_sum", int'(out_sum), e.sum);
                chk("frame_words", int'(out_words), e.words);
            end
        end
    end

    // mode 0: constant val; mode 1: i%10 sequence. gap inserts an idle cycle.
    task automatic send_words(input int n, input int mode, input int val, input bit gap);
        for (int i = 0; i < n; i++) begin
            int cnt;
            in_valid = 1'b1;
            in_count = (mode == 0) ? 4'(val) : 4'(i % 10);
            cnt = 0;
            @(negedge clk);
            while (!in_ready && cnt < 100) begin
                @(negedge clk);
                cnt++;
            end
            if (cnt >= 100) chk("in_ready_timeout", 0, 1);
            @(posedge clk);
            #1;
            if (gap) begin
                in_valid = 1'b0;
                @(posedge clk);
                #1;
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int cnt;
        cnt = 0;
        while (sb.size() != 0 && cnt < 100) begin
            @(negedge clk);
            cnt++;
        end
        if (sb.size() != 0) chk("drain_timeout", sb.size(), 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout t=%0t", $time);
        $fatal(1, "timeout");
    end

    initial begin
        int exp_err;
        int exp_t6;
`ifdef POPACC_RANGE_CHECK_EN
        exp_err = 1;
        exp_t6  = 9;
`else
        exp_err = 0;
        exp_t6  = 15;
`endif
        rst_n     = 1'b0;
        clear     = 1'b0;
        in_valid  = 1'b0;
        in_count  = 4'd0;
        out_ready = 1'b0;

        // reset state
        #12;
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_out_sum", int'(out_sum), 0);
        chk("rst_out_words", int'(out_words), 0);
        chk("rst_err", int'(err), 0);
        chk("rst_in_ready", int'(in_ready), 1);
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        out_ready = 1'b1;

        // 1: continuous 9s -> 144, one HOLD cycle
        push_exp(144, 16);
        send_words(16, 0, 9, 1'b0);
        @(negedge clk);
        chk("t1_hold_out_valid", int'(out_valid), 1);
        chk("t1_hold_in_ready", int'(in_ready), 0);
        @(negedge clk);
        chk("t1_after_in_ready", int'(in_ready), 1);
        chk("t1_after_out_valid", int'(out_valid), 0);
        @(posedge clk);
        #1;

        // 2: 0..9,0..5 with toggling valid -> 60
        push_exp(60, 16);
        send_words(16, 1, 0, 1'b1);
        drain();

        // 3: back-pressure for 5 cycles
        out_ready = 1'b0;
        push_exp(32, 16);
        send_words(16, 0, 2, 1'b0);
        in_valid = 1'b1;
        in_count = 4'd7;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("t3_stall_out_valid", int'(out_valid), 1);
            chk("t3_stall_out_sum", int'(out_sum), 32);
            chk("t3_stall_in_ready", int'(in_ready), 0);
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk("t3_hs_in_ready", int'(in_ready), 0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(negedge clk);
        chk("t3_post_in_ready", int'(in_ready), 1);
        chk("t3_post_out_valid", int'(out_valid), 0);
        chk("t3_sb_empty", sb.size(), 0);
        @(posedge clk);
        #1;

        // 4: clear mid-frame drops the simultaneous word
        send_words(7, 0, 5, 1'b0);
        clear    = 1'b1;
        in_valid = 1'b1;
        in_count = 4'd9;
        @(negedge clk);
        chk("t4_clear_in_ready", int'(in_ready), 0);
        @(posedge clk);
        #1;
        clear    = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        chk("t4_out_sum_kept", int'(out_sum), 32);
        @(posedge clk);
        #1;
        push_exp(16, 16);
        send_words(16, 0, 1, 1'b0);
        drain();

        // 5: async reset mid-frame and mid-HOLD
        send_words(5, 0, 3, 1'b0);
        #3;
        rst_n = 1'b0;
        #1;
        chk("t5a_out_valid", int'(out_valid), 0);
        chk("t5a_out_sum", int'(out_sum), 0);
        chk("t5a_err", int'(err), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("t5a_in_ready", int'(in_ready), 1);
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        send_words(16, 0, 1, 1'b0);
        @(negedge clk);
        chk("t5b_hold_out_valid", int'(out_valid), 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t5b_out_valid", int'(out_valid), 0);
        chk("t5b_out_sum", int'(out_sum), 0);
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        out_ready = 1'b1;
        push_exp(64, 16);
        send_words(16, 0, 4, 1'b0);
        drain();

        // 6: out-of-range word
        push_exp(exp_t6, 16);
        send_words(1, 0, 15, 1'b0);
        send_words(15, 0, 0, 1'b0);
        drain();
        @(negedge clk);
        chk("t6_err", int'(err), exp_err);
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        chk("t6_err_sticky", int'(err), exp_err);
        @(posedge clk);
        #1;
        clear = 1'b1;
        @(posedge clk);
        #1;
        clear = 1'b0;
        @(negedge clk);
        chk("t6_err_cleared", int'(err), 0);

        chk("final_sb_empty", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/popcount_frame_acc.md
Name: popcount_frame_acc

Overview:
- Downstream consumer of the nine-input single-bit adder.
- Accepts the adder's 4-bit ones-count (0..9) one word per handshake and accumulates FRAME_LEN words into a frame total.
- Presents the frame total on a valid/ready output port, for frame-level density statistics.

Parameters:
FRAME_LEN, 16, number of input words per frame; legal range is 1 or greater.
ACC_W, 8, accumulator/output width; must satisfy 2^ACC_W > 9*FRAME_LEN (default 144 fits in 8 bits).
WCNT_W, $clog2(FRAME_LEN)+1, width of the word counter; derived, not to be overridden.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
clear  input  1  synchronous frame abort/restart, highest priority
in_valid  input  1  in_count is valid this cycle
in_ready  output  1  block can accept a word this cycle
in_count  input  4  ones-count word {cout2,cout1,cout0,sum}, legal range 0..9
out_valid  output  1  frame total available
out_ready  input  1  downstream takes the frame total
out_sum  output  ACC_W  frame total
out_words  output  WCNT_W  words accumulated in the reported frame (always FRAME_LEN)
err  output  1  sticky out-of-range flag (see Optional Feature)

Behaviour:
- Reset (rst_n low, asynchronous): state=ACCUM, acc=0, wcnt=0, out_valid=0, out_sum=0, out_words=0, err=0. in_ready follows the state, so it is 1 after reset.
- State ACCUM:
  - in_ready=1, out_valid=0.
  - Accept when in_valid && in_ready: acc <= acc + in_count (zero-extended to ACC_W), wcnt <= wcnt+1.
  - When the accepted word is the last one (wcnt==FRAME_LEN-1):
    - out_sum <= acc + in_count; out_words <= FRAME_LEN; out_valid <= 1.
    - acc <= 0, wcnt <= 0, state <= HOLD.
  - Latency: out_valid rises the cycle after the last word is accepted.
- State HOLD:
  - in_ready=0; out_valid=1; out_sum and out_words stable.
  - On out_valid && out_ready: out_valid <= 0, state <= ACCUM. in_ready returns to 1 in the next cycle.
  - No input is accepted in the handshake cycle.
  - out_sum keeps its last value after the handshake until the next frame completes.
- Throughput: one frame per FRAME_LEN+1 cycles minimum with continuous in_valid and out_ready=1.
- FRAME_LEN=1: every accepted word produces a frame. out_sum equals that word.
- No overflow is possible given the ACC_W rule. No saturation logic is required.
- clear (synchronous, sampled on the rising edge):
  - Effect: acc=0, wcnt=0, out_valid=0, state=ACCUM, err=0. out_sum is not changed.
  - in_ready is forced to 0 while clear=1, so a simultaneous in_valid word is dropped, not accepted.
  - clear in HOLD discards the pending frame even if out_ready=1 in the same cycle; no handshake occurs.
- Reset mid-frame discards the partial frame and any pending output.
- in_count and in_valid need not be held stable when in_ready=0; the block samples them only on accept.

Optional Feature:
Macro POPACC_RANGE_CHECK_EN.
- Defined:
  - An accepted in_count > 9 sets err (sticky until clear or reset).
  - The value added to acc is clamped to 9.
- Undefined:
  - err is tied to 0.
  - in_count is added unmodified. The out-of-range word is still added, so the 9*FRAME_LEN bound no longer holds; the upstream adder guarantees the range.

Test Plan:
1. Reset, then FRAME_LEN=16 words each in_count=9 with in_valid=1 and out_ready=1 -> out_valid=1 one cycle after the 16th accept, out_sum=144, out_words=16; in_ready=0 for exactly the 1 HOLD cycle.
2. Words 0,1,2,...,9,0,1,2,3,4,5 with in_valid toggling 1/0 every cycle -> out_sum=60 on frame completion; no word lost or duplicated.
3. Frame completes with out_ready=0 for 5 cycles, in_valid held 1 -> out_valid and out_sum stable for those cycles, in_ready=0 throughout, no word accepted until one cycle after out_ready=1.
4. Accept 7 words of value 5, then assert clear together with in_valid (in_count=9) -> that word is not accepted; the next 16 words of value 1 give out_sum=16.
5. Assert rst_n=0 mid-frame and mid-HOLD, asynchronously between clock edges -> out_valid=0, out_sum=0 and err=0 immediately; in_ready=1 after release; the next frame sums from 0.
6. With POPACC_RANGE_CHECK_EN, FRAME_LEN=16, feed in_count=15 once then 15 words of value 0 -> err=1, out_sum=9; err remains 1 until clear. Without the macro, the same stimulus -> out_sum=15, err=0.
